// File: rtl/unidad_pc.sv
// Program-counter / next-PC stage of the RV32I core: PC register, redirect bubble,
// misaligned-target trap and taken-redirect counter.
module unidad_pc #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             instr_valida,
    input  logic             es_branch,
    input  logic             es_jal,
    input  logic             es_jalr,
    input  logic             z_branch,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1,
    output logic [31:0]      pc,
    output logic [31:0]      pc_mas4,
    output logic             flush,
    output logic             excepcion,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] cnt_tomados
);

    typedef enum logic [1:0] {Ejecuta, Descarte, Trap} estado_t;

    localparam logic [CNT_W-1:0] CntUno = CNT_W'(1);

    estado_t          estado_q, estado_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      epc_q, epc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic             exc_q, exc_d;

    logic [31:0]      destino_rel;
    logic [31:0]      destino_jalr;
    logic [31:0]      destino;
    logic             salta;

    assign pc_mas4      = pc_q + 32'd4;
    assign destino_rel  = pc_q + imm;
    assign destino_jalr = (rs1 + imm) & ~32'h1;

    // Redirect class priority: JALR, then JAL, then taken branch.
    always_comb begin
        salta   = 1'b0;
        destino = destino_rel;
        if (instr_valida) begin
            if (es_jalr) begin
                salta   = 1'b1;
                destino = destino_jalr;
            end else if (es_jal) begin
                salta = 1'b1;
            end else if (es_branch && z_branch) begin
                salta = 1'b1;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        cnt_d    = cnt_q;
        flush_d  = 1'b0;
        exc_d    = 1'b0;
        case (estado_q)
            Ejecuta: begin
                if (!salta) begin
                    pc_d = pc_mas4;
                end else if (destino[1:0] == 2'b00) begin
                    pc_d     = destino;
                    flush_d  = 1'b1;
                    cnt_d    = cnt_q + CntUno;
                    estado_d = Descarte;
                end else begin
                    pc_d     = TRAP_VECTOR;
                    epc_d    = pc_q;
                    exc_d    = 1'b1;
                    estado_d = Trap;
                end
            end
            Descarte: estado_d = Ejecuta;
            Trap:     estado_d = Ejecuta;
            default:  estado_d = Ejecuta;
        endcase
    end

    // A stall freezes everything, including any pulse waiting to be emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= Ejecuta;
            pc_q     <= RESET_PC;
            epc_q    <= 32'h0;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            exc_q    <= 1'b0;
        end else if (!stall) begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            exc_q    <= exc_d;
        end
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign cnt_tomados = cnt_q;
    assign flush       = flush_q & ~stall;
    assign excepcion   = exc_q & ~stall;

endmodule

// File: tb/tb_unidad_pc.sv
// Directed bench for unidad_pc: per-cycle expectations go through a scoreboard queue
// and are compared against the DUT outputs mid-cycle.
module tb_unidad_pc;

    logic        clk = 1'b0;
    logic        reset, stall, instr_valida, es_branch, es_jal, es_jalr, z_branch;
    logic [31:0] imm, rs1;
    logic [31:0] pc, pc_mas4, epc;
    logic        flush, excepcion;
    logic [3:0]  cnt_tomados;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        ex;
        logic [31:0] epc;
        logic [3:0]  cnt;
    } esperado_t;

    esperado_t sb[$];

    unidad_pc #(
        .RESET_PC    (32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .instr_valida (instr_valida),
        .es_branch    (es_branch),
        .es_jal       (es_jal),
        .es_jalr      (es_jalr),
        .z_branch     (z_branch),
        .imm          (imm),
        .rs1          (rs1),
        .pc           (pc),
        .pc_mas4      (pc_mas4),
        .flush        (flush),
        .excepcion    (excepcion),
        .epc          (epc),
        .cnt_tomados  (cnt_tomados)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the outputs of that same cycle, then clock.
    task automatic step(input logic rs, input logic st, input logic v, input logic br,
                        input logic jl, input logic jr, input logic z,
                        input logic [31:0] im, input logic [31:0] r1,
                        input logic [31:0] e_pc, input logic e_fl, input logic e_ex,
                        input logic [31:0] e_epc, input logic [3:0] e_cnt);
        esperado_t e;
        logic [31:0] e_mas4;
        reset = rs; stall = st; instr_valida = v; es_branch = br;
        es_jal = jl; es_jalr = jr; z_branch = z; imm = im; rs1 = r1;
        sb.push_back('{pc: e_pc, fl: e_fl, ex: e_ex, epc: e_epc, cnt: e_cnt});
        #1;
        e = sb.pop_front();
        e_mas4 = e.pc + 32'd4;
        chk("pc",        pc,                 e.pc);
        chk("pc_mas4",   pc_mas4,            e_mas4);
        chk("flush",     {31'b0, flush},     {31'b0, e.fl});
        chk("excepcion", {31'b0, excepcion}, {31'b0, e.ex});
        chk("epc",       epc,                e.epc);
        chk("cnt",       {28'b0, cnt_tomados}, {28'b0, e.cnt});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] p;
        logic [3:0]  c;
        reset = 1'b1; stall = 1'b0; instr_valida = 1'b0; es_branch = 1'b0;
        es_jal = 1'b0; es_jalr = 1'b0; z_branch = 1'b0; imm = '0; rs1 = '0;
        @(posedge clk);
        #1;

        // Free-running sequential fetch after reset.
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   0,0, 32'h0, 4'd0);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h4,   0,0, 32'h0, 4'd0);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h8,   0,0, 32'h0, 4'd0);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'hC,   0,0, 32'h0, 4'd0);
        // Taken branch; JAL presented during the bubble must be ignored.
        step(0,0,1,1,0,0,1, 32'h20,  32'h0,   32'h10,  0,0, 32'h0, 4'd0);
        step(0,0,1,0,1,0,0, 32'h40,  32'h0,   32'h30,  1,0, 32'h0, 4'd1);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h30,  0,0, 32'h0, 4'd1);
        // Not-taken branch.
        step(0,0,1,1,0,0,0, 32'h20,  32'h0,   32'h34,  0,0, 32'h0, 4'd1);
        // JALR aligned after bit-0 clear, then misaligned JALR traps.
        step(0,0,1,0,0,1,0, 32'h3,   32'h101, 32'h38,  0,0, 32'h0, 4'd1);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h104, 1,0, 32'h0, 4'd2);
        step(0,0,1,0,0,1,0, 32'h2,   32'h100, 32'h104, 0,0, 32'h0, 4'd2);
        step(0,0,1,0,0,1,0, 32'h2,   32'h100, 32'h100, 0,1, 32'h104, 4'd2);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h100, 0,0, 32'h104, 4'd2);
        // JAL and JALR together: JALR wins.
        step(0,0,1,0,1,1,0, 32'h40,  32'h200, 32'h104, 0,0, 32'h104, 4'd2);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h240, 1,0, 32'h104, 4'd3);
        // Not-taken branch with a misaligned target never faults.
        step(0,0,1,1,0,0,0, 32'h2,   32'h0,   32'h240, 0,0, 32'h104, 4'd3);
        // JAL with instr_valida low is sequential.
        step(0,0,0,0,1,0,0, 32'h40,  32'h0,   32'h244, 0,0, 32'h104, 4'd3);
        // Stall across a redirect, then across the bubble.
        step(0,1,1,0,1,0,0, 32'h10,  32'h0,   32'h248, 0,0, 32'h104, 4'd3);
        step(0,1,1,0,1,0,0, 32'h10,  32'h0,   32'h248, 0,0, 32'h104, 4'd3);
        step(0,1,1,0,1,0,0, 32'h10,  32'h0,   32'h248, 0,0, 32'h104, 4'd3);
        step(0,0,1,0,1,0,0, 32'h10,  32'h0,   32'h248, 0,0, 32'h104, 4'd3);
        step(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h258, 0,0, 32'h104, 4'd4);
        step(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h258, 0,0, 32'h104, 4'd4);
        step(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h258, 0,0, 32'h104, 4'd4);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h258, 1,0, 32'h104, 4'd4);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h258, 0,0, 32'h104, 4'd4);
        // Trap, then reset while in the trap bubble.
        step(0,0,1,0,0,1,0, 32'h0,   32'h302, 32'h25C, 0,0, 32'h104, 4'd4);
        step(1,0,0,0,0,0,0, 32'h0,   32'h0,   32'h100, 0,1, 32'h25C, 4'd4);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   0,0, 32'h0,   4'd0);
        // JAL to the top of the address space, then sequential wrap.
        step(0,0,1,0,1,0,0, 32'hFFFF_FFF8, 32'h0, 32'h4, 0,0, 32'h0, 4'd0);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'hFFFF_FFFC, 1,0, 32'h0, 4'd1);
        step(0,0,0,0,0,0,0, 32'h0,   32'h0,   32'hFFFF_FFFC, 0,0, 32'h0, 4'd1);

        // Counter wraps 0xF -> 0x0 through repeated JALs.
        p = 32'h0;
        c = 4'd1;
        for (int i = 0; i < 15; i++) begin
            step(0,0,1,0,1,0,0, 32'h8, 32'h0, p,         0,0, 32'h0, c);
            step(0,0,0,0,0,0,0, 32'h0, 32'h0, p + 32'h8, 1,0, 32'h0, c + 4'd1);
            p = p + 32'h8;
            c = c + 4'd1;
        end
        step(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h78, 0,0, 32'h0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidad_pc.md
Name: unidad_pc

Overview:
- Program-counter and next-PC stage of the RV32I core.
- Sits directly downstream of the branch-condition selector. It consumes the resolved condition `z_branch` plus the decoded jump/branch class and immediate.
- Owns the PC register, redirect bubbles, the misaligned-target trap and a taken-branch counter.
- Feeds instruction memory address (`pc`) and the link value (`pc_mas4`) for JAL/JALR writeback.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on misaligned-target exception.
- CNT_W, 16: width of taken-redirect counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  freeze all state this cycle
- instr_valida  input  1  control inputs below are meaningful this cycle
- es_branch  input  1  current instruction is a conditional branch
- es_jal  input  1  current instruction is JAL
- es_jalr  input  1  current instruction is JALR
- z_branch  input  1  branch condition satisfied (from condition selector)
- imm  input  32  sign-extended immediate (B/J/I format)
- rs1  input  32  rs1 operand value (JALR base)
- pc  output  32  current PC (registered)
- pc_mas4  output  32  pc + 4, combinational, modulo 2^32
- flush  output  1  registered 1-cycle pulse: discard instruction fetched after redirect
- excepcion  output  1  registered 1-cycle pulse: misaligned target trap taken
- epc  output  32  PC of the faulting instruction (registered)
- cnt_tomados  output  CNT_W  count of taken redirects (branch taken, JAL, JALR), wraps

Behaviour:

Reset (synchronous, overrides stall):
- pc = RESET_PC, flush = 0, excepcion = 0, epc = 0, cnt_tomados = 0, state = EJECUTA.

Stall:
- stall = 1 holds pc, epc, cnt_tomados and state.
- flush and excepcion are forced to 0 during a stall cycle; a pending pulse is not lost, it is emitted on the first non-stalled cycle.

Targets:
- Branch/JAL target = pc + imm.
- JALR target = (rs1 + imm) with bit 0 cleared.
- All arithmetic is 32-bit modulo 2^32.

Redirect selection (evaluated in EJECUTA when instr_valida = 1):
- Priority: es_jalr > es_jal > (es_branch & z_branch) > sequential.
- More than one class asserted is legal; the priority above resolves it.
- Redirect: the selected target is used.
- Sequential (no redirect class, branch not taken, or instr_valida = 0): next pc = pc + 4.

States:
- EJECUTA
  - No redirect: pc <= pc + 4.
  - Redirect with target[1:0] == 00: pc <= target, flush <= 1, cnt_tomados += 1, go to DESCARTE.
  - Redirect with target[1:0] != 00: pc <= TRAP_VECTOR, epc <= pc, excepcion <= 1, go to TRAP. cnt_tomados is not incremented.
  - A not-taken branch never faults, whatever its target.
- DESCARTE (one bubble)
  - pc held, all control inputs ignored, flush <= 0, go to EJECUTA.
- TRAP (one bubble)
  - pc held at TRAP_VECTOR, control inputs ignored, excepcion <= 0, go to EJECUTA.

Timing:
- Redirect latency: pc shows the target one cycle after the instruction is presented.
- flush and excepcion are asserted in that same cycle, for exactly one cycle.

Boundaries:
- pc = 32'hFFFF_FFFC with a sequential step wraps to 32'h0000_0000.
- cnt_tomados wraps from all-ones to 0.
- Reset asserted while in DESCARTE or TRAP returns to EJECUTA immediately and clears the pulses.
- Stall asserted in DESCARTE/TRAP extends that state; no input is sampled until it resolves.

Test Plan:
1. Reset, then 4 free-running cycles with instr_valida = 0 -> pc sequence 0x0, 0x4, 0x8, 0xC, 0x10; flush = excepcion = 0.
2. At pc = 0x10: es_branch = 1, z_branch = 1, imm = 0x20 -> next cycle pc = 0x30, flush = 1, cnt_tomados = 1; following cycle pc = 0x30 (bubble), flush = 0; then 0x34. Repeat with z_branch = 0 -> pc = 0x14, no flush, counter unchanged.
3. JALR with rs1 = 0x101, imm = 0x3 -> target 0x104, pc = 0x104, flush pulse. JALR with rs1 = 0x100, imm = 0x2 -> target 0x102 misaligned -> pc = 0x100 (TRAP_VECTOR), excepcion = 1 for one cycle, epc = faulting pc, counter unchanged.
4. es_jal = 1 and es_jalr = 1 together (imm = 0x40, rs1 = 0x200) -> JALR wins, pc = 0x240. Also es_branch = 1, z_branch = 0, imm = 0x2 -> no trap, pc + 4.
5. Stall held 3 cycles during a redirect, and during the DESCARTE bubble -> pc frozen, flush withheld; flush is emitted exactly once after stall drops. Reset asserted during TRAP -> pc = RESET_PC next cycle, excepcion = 0.
6. Force pc = 0xFFFF_FFFC via JAL target -> next sequential pc = 0x0, pc_mas4 shows 0x0 at 0xFFFF_FFFC. Preload the counter near all-ones via repeated JALs (CNT_W = 4 override) -> cnt_tomados wraps 0xF -> 0x0.
